// File: rtl/rv_load_store_unit.sv
// Data-memory access unit: alignment check, lane formatting, single-outstanding
// req/ack bus cycle with timeout, and registered load/store completion flags.
module rv_load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_addr_i,
  input  logic [31:0] x_store_value_i,
  input  logic        x_kill_i,
  input  logic        x_advance_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic [3:0]  dm_sel_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_misaligned_o,
  output logic        dm_bus_error_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_DRAIN} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_is_load;
  logic        r_killed;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic [31:0] r_data_l;
  logic        r_load_done;
  logic        r_store_done;
  logic        r_misaligned;
  logic        r_bus_error;

  logic        w_start;
  logic        w_misaligned;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic        w_killed;
  logic        w_unused_fun;

  // Signedness (fun[2]) only matters to writeback's extension logic.
  assign w_unused_fun = x_fun_i[2];
  assign w_start      = (x_load_i | x_store_i) & ~x_kill_i;
  assign w_killed     = r_killed | x_kill_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_misaligned = 1'b0;
    w_sel        = 4'b1111;
    w_wdata      = x_store_value_i;
    case (x_fun_i[1:0])
      2'b00: begin
        w_sel   = 4'b0001 << x_addr_i[1:0];
        w_wdata = {4{x_store_value_i[7:0]}};
      end
      2'b01: begin
        w_misaligned = x_addr_i[0];
        w_sel        = x_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{x_store_value_i[15:0]}};
      end
      default: w_misaligned = |x_addr_i[1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_is_load    <= 1'b0;
      r_killed     <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sel        <= '0;
      r_data_l     <= '0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          if (w_misaligned) begin
            r_misaligned <= 1'b1;
            r_load_done  <= x_load_i;
            r_store_done <= x_store_i;
            r_state      <= S_DONE;
          end else begin
            r_req     <= 1'b1;
            r_we      <= x_store_i;
            r_addr    <= {x_addr_i[31:2], 2'b00};
            r_sel     <= x_store_i ? w_sel : 4'b1111;
            r_wdata   <= w_wdata;
            r_is_load <= x_load_i;
            r_killed  <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          // Ack is tested first so it wins over a simultaneous terminal count.
          if (dm_ack_i) begin
            r_req <= 1'b0;
            if (w_killed) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_DONE;
              if (r_is_load) begin
                r_data_l    <= dm_rdata_i;
                r_load_done <= 1'b1;
              end else begin
                r_store_done <= 1'b1;
              end
            end
          end else if (r_cnt == TIMEOUT_CNT) begin
            r_req <= 1'b0;
            if (w_killed) begin
              r_state <= S_DRAIN;
            end else begin
              r_state     <= S_DONE;
              r_bus_error <= 1'b1;
              if (r_is_load) begin
                r_data_l    <= '0;
                r_load_done <= 1'b1;
              end else begin
                r_store_done <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (x_kill_i) r_killed <= 1'b1;
          end
        end
        S_DONE: if (x_advance_i | x_kill_i) begin
          r_load_done  <= 1'b0;
          r_store_done <= 1'b0;
          r_misaligned <= 1'b0;
          r_bus_error  <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dm_req_o        = r_req;
  assign dm_we_o         = r_we;
  assign dm_addr_o       = r_addr;
  assign dm_wdata_o      = r_wdata;
  assign dm_sel_o        = r_sel;
  assign dm_data_l_o     = r_data_l;
  assign dm_load_done_o  = r_load_done;
  assign dm_store_done_o = r_store_done;
  assign dm_misaligned_o = r_misaligned;
  assign dm_bus_error_o  = r_bus_error;

endmodule

// File: tb/tb_rv_load_store_unit.sv
// Bench for rv_load_store_unit: directed scenarios with cycle checks, plus a
// scoreboard of expected completions compared by a negedge monitor.
module tb_rv_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        x_load_i = 1'b0, x_store_i = 1'b0, x_kill_i = 1'b0, x_advance_i = 1'b0;
  logic [2:0]  x_fun_i = 3'b000;
  logic [31:0] x_addr_i = '0, x_store_value_i = '0;
  logic        dm_req_o, dm_we_o, dm_ack_i = 1'b0;
  logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i = '0, dm_data_l_o;
  logic [3:0]  dm_sel_o;
  logic        dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_error_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  flags;  // {load_done, store_done, misaligned, bus_error}
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model_data_l = '0;
  logic        prev_done = 1'b0;

  rv_load_store_unit #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .x_load_i(x_load_i), .x_store_i(x_store_i), .x_fun_i(x_fun_i),
    .x_addr_i(x_addr_i), .x_store_value_i(x_store_value_i),
    .x_kill_i(x_kill_i), .x_advance_i(x_advance_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .dm_sel_o(dm_sel_o),
    .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
    .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
    .dm_store_done_o(dm_store_done_o), .dm_misaligned_o(dm_misaligned_o),
    .dm_bus_error_o(dm_bus_error_o)
  );

  always #5 clk = ~clk;

  // Completion monitor: each rising done flag pops one expected result.
  always @(negedge clk) begin
    logic w_done;
    exp_t e;
    w_done = dm_load_done_o | dm_store_done_o;
    if (!rst_i && w_done && !prev_done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_completion: got flags=%b, required none", {dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_error_o});
      end else begin
        e = sb.pop_front();
        if ({dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_error_o} !== e.flags) begin
          n_bad++;
          $display("FAIL sb_flags: got %b required %b", {dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_error_o}, e.flags);
        end
        n_cmp++;
        if (dm_data_l_o !== e.data) begin
          n_bad++;
          $display("FAIL sb_data_l: got %h required %h", dm_data_l_o, e.data);
        end
      end
    end
    prev_done = w_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] fun, input logic [31:0] addr, input logic [31:0] val);
    x_load_i = ld; x_store_i = ~ld; x_fun_i = fun; x_addr_i = addr; x_store_value_i = val;
  endtask

  task automatic push(input logic [3:0] flags, input logic [31:0] data);
    exp_t e;
    e.flags = flags; e.data = data;
    sb.push_back(e);
  endtask

  task automatic advance();
    x_advance_i = 1'b1;
    tick();
    x_advance_i = 1'b0; x_load_i = 1'b0; x_store_i = 1'b0;
    n_cmp++;
    if ({dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_error_o} !== 4'b0000) begin
      n_bad++; $display("FAIL advance_clear: flags=%b required 0000", {dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_error_o});
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    n_cmp++;
    if ({dm_req_o, dm_we_o, dm_sel_o} !== 6'b0) begin n_bad++; $display("FAIL reset_ctl: got %b required 000000", {dm_req_o, dm_we_o, dm_sel_o}); end
    n_cmp++;
    if ({dm_addr_o, dm_wdata_o, dm_data_l_o} !== 96'b0) begin n_bad++; $display("FAIL reset_data: addr=%h wdata=%h data_l=%h required 0", dm_addr_o, dm_wdata_o, dm_data_l_o); end
    n_cmp++;
    if ({dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_error_o} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b required 0000", {dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_error_o}); end
  endtask

  task automatic test_store_byte();
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    push(4'b0100, model_data_l);
    tick();
    n_cmp++;
    if ({dm_req_o, dm_we_o, dm_sel_o} !== 6'b11_1000) begin n_bad++; $display("FAIL sb_bus_ctl: got %b required 111000", {dm_req_o, dm_we_o, dm_sel_o}); end
    n_cmp++;
    if (dm_addr_o !== 32'h0000_1000 || dm_wdata_o !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_bus_data: addr=%h wdata=%h required 00001000 a5a5a5a5", dm_addr_o, dm_wdata_o); end
    n_cmp++;
    if (dm_store_done_o !== 1'b0) begin n_bad++; $display("FAIL sb_early_done: got %b required 0", dm_store_done_o); end
    dm_ack_i = 1'b1; tick(); dm_ack_i = 1'b0;
    n_cmp++;
    if ({dm_req_o, dm_store_done_o} !== 2'b01) begin n_bad++; $display("FAIL sb_done: req/done=%b required 01", {dm_req_o, dm_store_done_o}); end
    tick(); tick();
    n_cmp++;
    if (dm_store_done_o !== 1'b1 || dm_req_o !== 1'b0) begin n_bad++; $display("FAIL sb_hold: done=%b req=%b required 1 0", dm_store_done_o, dm_req_o); end
    advance();
  endtask

  task automatic test_load_wait();
    issue(1'b1, 3'b010, 32'h0000_2000, 32'h0);
    model_data_l = 32'hDEAD_BEEF;
    push(4'b1000, model_data_l);
    tick();
    n_cmp++;
    if ({dm_req_o, dm_we_o, dm_sel_o} !== 6'b10_1111 || dm_addr_o !== 32'h0000_2000) begin
      n_bad++; $display("FAIL lw_bus: ctl=%b addr=%h required 101111 00002000", {dm_req_o, dm_we_o, dm_sel_o}, dm_addr_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({dm_req_o, dm_load_done_o} !== 2'b10) begin n_bad++; $display("FAIL lw_wait%0d: req/done=%b required 10", i, {dm_req_o, dm_load_done_o}); end
    end
    dm_ack_i = 1'b1; dm_rdata_i = 32'hDEAD_BEEF; tick(); dm_ack_i = 1'b0; dm_rdata_i = '0;
    n_cmp++;
    if ({dm_req_o, dm_load_done_o} !== 2'b01 || dm_data_l_o !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL lw_done: req/done=%b data=%h required 01 deadbeef", {dm_req_o, dm_load_done_o}, dm_data_l_o);
    end
    advance();
  endtask

  task automatic test_misaligned();
    issue(1'b1, 3'b001, 32'h0000_2001, 32'h0);
    push(4'b1010, model_data_l);
    tick();
    n_cmp++;
    if ({dm_req_o, dm_load_done_o, dm_misaligned_o} !== 3'b011) begin n_bad++; $display("FAIL lh_misaligned: req/done/mis=%b required 011", {dm_req_o, dm_load_done_o, dm_misaligned_o}); end
    advance();
    issue(1'b0, 3'b010, 32'h0000_1002, 32'h1111_2222);
    push(4'b0110, model_data_l);
    tick();
    n_cmp++;
    if ({dm_req_o, dm_store_done_o, dm_misaligned_o} !== 3'b011) begin n_bad++; $display("FAIL sw_misaligned: req/done/mis=%b required 011", {dm_req_o, dm_store_done_o, dm_misaligned_o}); end
    advance();
  endtask

  task automatic test_timeout();
    issue(1'b1, 3'b010, 32'h0000_4000, 32'h0);
    model_data_l = 32'h0;
    push(4'b1001, model_data_l);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({dm_req_o, dm_bus_error_o} !== 2'b10) begin n_bad++; $display("FAIL to_wait%0d: req/err=%b required 10", i, {dm_req_o, dm_bus_error_o}); end
    end
    tick();
    n_cmp++;
    if ({dm_req_o, dm_bus_error_o, dm_load_done_o} !== 3'b011 || dm_data_l_o !== 32'h0) begin
      n_bad++; $display("FAIL to_fire: req/err/done=%b data=%h required 011 00000000", {dm_req_o, dm_bus_error_o, dm_load_done_o}, dm_data_l_o);
    end
    advance();
    // Ack arriving on the terminal-count cycle must complete without error.
    issue(1'b1, 3'b010, 32'h0000_4004, 32'h0);
    model_data_l = 32'h1234_5678;
    push(4'b1000, model_data_l);
    tick();
    for (int i = 0; i < 4; i++) tick();
    dm_ack_i = 1'b1; dm_rdata_i = 32'h1234_5678; tick(); dm_ack_i = 1'b0; dm_rdata_i = '0;
    n_cmp++;
    if ({dm_bus_error_o, dm_load_done_o} !== 2'b01 || dm_data_l_o !== 32'h1234_5678) begin
      n_bad++; $display("FAIL to_ack_wins: err/done=%b data=%h required 01 12345678", {dm_bus_error_o, dm_load_done_o}, dm_data_l_o);
    end
    advance();
  endtask

  task automatic test_kill();
    issue(1'b0, 3'b010, 32'h0000_5000, 32'hCAFE_F00D);
    tick();
    n_cmp++;
    if (dm_wdata_o !== 32'hCAFE_F00D || dm_sel_o !== 4'b1111 || dm_we_o !== 1'b1) begin
      n_bad++; $display("FAIL kill_bus: wdata=%h sel=%b we=%b required cafef00d 1111 1", dm_wdata_o, dm_sel_o, dm_we_o);
    end
    x_kill_i = 1'b1; x_store_i = 1'b0; tick(); x_kill_i = 1'b0;
    tick();
    n_cmp++;
    if (dm_req_o !== 1'b1) begin n_bad++; $display("FAIL kill_req_held: req=%b required 1", dm_req_o); end
    dm_ack_i = 1'b1; tick(); dm_ack_i = 1'b0;
    n_cmp++;
    if ({dm_req_o, dm_store_done_o, dm_load_done_o} !== 3'b000) begin n_bad++; $display("FAIL kill_no_done: req/sd/ld=%b required 000", {dm_req_o, dm_store_done_o, dm_load_done_o}); end
    issue(1'b1, 3'b010, 32'h0000_6000, 32'h0);
    model_data_l = 32'h0BAD_F00D;
    push(4'b1000, model_data_l);
    tick();
    n_cmp++;
    if (dm_req_o !== 1'b0) begin n_bad++; $display("FAIL kill_drain: req=%b required 0 during drain", dm_req_o); end
    tick();
    n_cmp++;
    if (dm_req_o !== 1'b1 || dm_addr_o !== 32'h0000_6000) begin n_bad++; $display("FAIL kill_next_req: req=%b addr=%h required 1 00006000", dm_req_o, dm_addr_o); end
    dm_ack_i = 1'b1; dm_rdata_i = 32'h0BAD_F00D; tick(); dm_ack_i = 1'b0; dm_rdata_i = '0;
    n_cmp++;
    if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL kill_next_done: done=%b data=%h required 1 0badf00d", dm_load_done_o, dm_data_l_o); end
    advance();
  endtask

  task automatic test_reset_mid_req();
    issue(1'b1, 3'b010, 32'h0000_7000, 32'h0);
    tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0; x_load_i = 1'b0;
    model_data_l = 32'h0;
    n_cmp++;
    if ({dm_req_o, dm_we_o, dm_sel_o, dm_addr_o, dm_wdata_o, dm_data_l_o} !== '0) begin
      n_bad++; $display("FAIL rst_mid_req: req=%b sel=%b addr=%h data_l=%h required all 0", dm_req_o, dm_sel_o, dm_addr_o, dm_data_l_o);
    end
    issue(1'b1, 3'b000, 32'h0000_3002, 32'h0);
    model_data_l = 32'h0080_0000;
    push(4'b1000, model_data_l);
    tick();
    n_cmp++;
    if (dm_req_o !== 1'b1 || dm_sel_o !== 4'b1111 || dm_addr_o !== 32'h0000_3000) begin
      n_bad++; $display("FAIL lb_bus: req=%b sel=%b addr=%h required 1 1111 00003000", dm_req_o, dm_sel_o, dm_addr_o);
    end
    dm_ack_i = 1'b1; dm_rdata_i = 32'h0080_0000; tick(); dm_ack_i = 1'b0; dm_rdata_i = '0;
    n_cmp++;
    if (dm_load_done_o !== 1'b1 || dm_data_l_o !== 32'h0080_0000) begin n_bad++; $display("FAIL lb_done: done=%b data=%h required 1 00800000", dm_load_done_o, dm_data_l_o); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  offs [3] = '{2'd0, 2'd2, 2'd1};
    logic [3:0]  sels [3] = '{4'b0001, 4'b0100, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 3'b000, 32'h0000_8000 | 32'(offs[i]), 32'h0000_0100 + 32'(i));
      push(4'b0100, model_data_l);
      tick();
      n_cmp++;
      if (dm_sel_o !== sels[i] || dm_wdata_o !== {4{8'(i)}}) begin
        n_bad++; $display("FAIL b2b_sb%0d: sel=%b wdata=%h required %b %h", i, dm_sel_o, dm_wdata_o, sels[i], {4{8'(i)}});
      end
      dm_ack_i = 1'b1; tick(); dm_ack_i = 1'b0;
      advance();
    end
    issue(1'b0, 3'b001, 32'h0000_1002, 32'h1234_BEEF);
    push(4'b0100, model_data_l);
    tick();
    n_cmp++;
    if (dm_sel_o !== 4'b1100 || dm_wdata_o !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL sh_lanes: sel=%b wdata=%h required 1100 beefbeef", dm_sel_o, dm_wdata_o); end
    dm_ack_i = 1'b1; tick(); dm_ack_i = 1'b0;
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_byte();
    test_load_wait();
    test_misaligned();
    test_timeout();
    test_kill();
    test_reset_mid_req();
    test_back_to_back();
    tick(); tick();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: %0d pending, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_load_store_unit.md
# rv_load_store_unit

Data-memory access unit sitting between the execute stage and `rv_writeback`. Accepts one load or store per instruction from execute, checks alignment, drives a single-outstanding request/acknowledge data bus with byte-lane selects, and returns the raw 32-bit load word plus load/store completion flags. Writeback uses these to sign/zero-extend loads and to release its stall request. A bus timeout guarantees completion even if the slave never answers.

## Interface
- `TIMEOUT`, 255: REQ-state cycles without `dm_ack_i` before a bus error; 1..65535; counter is 16 bits.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `x_load_i` in 1: execute holds a load.
- `x_store_i` in 1: execute holds a store; never high together with `x_load_i`.
- `x_fun_i` in 3: access type: B=000, H=001, L=010, BU=100, HU=101.
- `x_addr_i` in 32: byte address.
- `x_store_value_i` in 32: rs2 value, store data in low bits.
- `x_kill_i` in 1: current instruction squashed.
- `x_advance_i` in 1: one-cycle pulse when writeback retires the instruction; x_* inputs change after it.
- `dm_req_o` out 1: bus request, held until ack.
- `dm_we_o` out 1: 1 = write.
- `dm_addr_o` out 32: word address; bits [1:0] forced 0.
- `dm_wdata_o` out 32: lane-replicated store data.
- `dm_sel_o` out 4: byte-lane enables.
- `dm_ack_i` in 1: slave acknowledge; `dm_rdata_i` valid in the same cycle.
- `dm_rdata_i` in 32: read data.
- `dm_data_l_o` out 32: latched raw load word.
- `dm_load_done_o` out 1: load completed.
- `dm_store_done_o` out 1: store completed.
- `dm_misaligned_o` out 1: alignment fault; no bus cycle issued.
- `dm_bus_error_o` out 1: timeout fault.

## Operation
- States: IDLE, REQ, DONE, DRAIN.
- IDLE: if (`x_load_i`|`x_store_i`) & !`x_kill_i`:
  - misaligned (H/HU with addr[0]=1; L with addr[1:0]≠0): go to DONE with `dm_misaligned_o`=1 and the matching done flag=1.
  - otherwise: register bus outputs, go to REQ.
- Store lanes:
  - B: data byte replicated ×4; sel = 0001 << addr[1:0].
  - H: halfword replicated ×2; sel = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - L: full word; sel = 1111.
- Loads: sel=1111, `dm_we_o`=0; `dm_wdata_o` is don't-care.
- REQ: `dm_req_o`=1, all bus outputs stable; timeout counter increments each cycle.
  - On `dm_ack_i`: latch `dm_rdata_i` (loads only), drop `dm_req_o`, go to DONE, set the done flag.
  - `x_kill_i` seen in REQ: transaction still completes; on ack go to DRAIN instead of DONE, no done flag.
  - Counter reaches `TIMEOUT` without ack: drop `dm_req_o`, set `dm_bus_error_o` plus the done flag, go to DONE. Load data is then 0.
- DONE: hold flags and `dm_data_l_o` until `x_advance_i` or `x_kill_i`, then clear the flags and go to IDLE.
- DRAIN: one cycle, flags cleared, then IDLE.
- `dm_data_l_o` keeps its last latched value outside of load completion.

## Timing
- Reset values: `dm_req_o`=0, `dm_we_o`=0, `dm_addr_o`=0, `dm_wdata_o`=0, `dm_sel_o`=0, `dm_data_l_o`=0, all done/error flags 0; state IDLE; counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Zero-wait slave:
  - Request accepted at edge N; `dm_req_o` high after N.
  - `dm_ack_i` sampled at edge N+1; done flags high after N+1.
  - Load-to-done latency 2 cycles.
- Each wait state adds one cycle.
- Misaligned access: done and misaligned flags high after edge N; no bus activity.
- `x_advance_i` in DONE: flags low after that edge; the next request is accepted no earlier than the following edge (one bubble).
- Timeout: error and done flags high after the edge on which the counter equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after request issue.
- Simultaneous `dm_ack_i` and timeout terminal count: ack wins, no error.
- `x_advance_i` outside DONE is ignored.
- `rst_i` mid-REQ: `dm_req_o` low after that edge; the transaction is abandoned.

## Test plan
- SB to 0x1003, rs2=0x000000A5, ack same cycle → `dm_wdata_o`=0xA5A5A5A5, `dm_sel_o`=1000, `dm_addr_o`=0x1000, `dm_store_done_o` high 2 cycles after request accept, held until advance.
- LW from 0x2000, ack after 3 wait cycles, rdata=0xDEADBEEF → `dm_data_l_o`=0xDEADBEEF, `dm_load_done_o` 5 cycles after accept; cleared the cycle after `x_advance_i`.
- LH at 0x2001 → no `dm_req_o`, `dm_misaligned_o`=1 and `dm_load_done_o`=1 one cycle after accept.
- TIMEOUT=4, LW with no ack → `dm_req_o` drops, `dm_bus_error_o`=1 and `dm_load_done_o`=1 with `dm_data_l_o`=0, 5 cycles after request issue.
- SW issued, `x_kill_i` during REQ, ack 2 cycles later → no done flag, DRAIN one cycle, then a new LW is accepted normally.
- `rst_i` asserted during REQ → all outputs at reset values next cycle; a subsequent LB from 0x3002, rdata=0x00800000 → `dm_data_l_o`=0x00800000, `dm_load_done_o`=1.
